// File: rtl/sh7604_int_seq_pkg.sv
// Shared types and constants for the SH7604 interrupt exception sequencer.
package sh7604_int_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_VREQ   = 3'd2,
        S_VWAIT  = 3'd3,
        S_PSR    = 3'd4,
        S_PPC    = 3'd5,
        S_FETCH  = 3'd6,
        S_DONE   = 3'd7
    } intseq_state_t;

    localparam logic [3:0] NMI_LEVEL = 4'hF;

    // Vector table entry address; wraps modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [7:0]  vec,
                                             input int unsigned shift);
        return base + ({24'h000000, vec} << shift);
    endfunction

endpackage

// File: rtl/sh7604_int_seq.sv
// SH7604 interrupt exception sequencer: INTC handshake, SR/PC push, vector fetch.
// Optional INT_COUNT statistics output when SH7604_INTSEQ_STATS_EN is defined.
module sh7604_int_seq
    import sh7604_int_seq_pkg::*;
#(
    parameter int unsigned VEC_SHIFT = 2,
    parameter int unsigned SP_STEP   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        EN,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic        NMI_REQ,
    output logic        INT_ACP,
    output logic        INT_ACK,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    input  logic [7:0]  INT_VEC,
    input  logic        BOUNDARY,
    input  logic [31:0] SR_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] SP_IN,
    input  logic [31:0] VBR,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_DO,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic [31:0] MEM_DI,
    input  logic        MEM_WAIT,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_SP,
    output logic [3:0]  NEW_MASK
`ifdef SH7604_INTSEQ_STATS_EN
    ,
    output logic [15:0] INT_COUNT
`endif
);

    localparam logic [31:0] SP_STEP1_W = 32'(SP_STEP);
    localparam logic [31:0] SP_STEP2_W = 32'(2 * SP_STEP);

    intseq_state_t state_r, state_nxt_s;
    logic          advance_s, accept_s;
    logic          ce_f_unused_s;

    logic [3:0]    lvl_r;
    logic [31:0]   sr_r, pc_r, sp_r, vbr_r;
    logic [7:0]    vec_r;

    logic          int_acp_r, int_ack_r, vect_req_r, mem_we_r, mem_req_r, busy_r, done_r;
    logic [31:0]   mem_a_r, mem_do_r, new_pc_r, new_sp_r;
    logic [3:0]    new_mask_r;

    logic          int_acp_nxt_s, int_ack_nxt_s, vect_req_nxt_s, mem_we_nxt_s;
    logic          mem_req_nxt_s, busy_nxt_s, done_nxt_s;
    logic [31:0]   mem_a_nxt_s, mem_do_nxt_s, new_pc_nxt_s, new_sp_nxt_s;
    logic [3:0]    new_mask_nxt_s;

    assign ce_f_unused_s = CE_F;
    assign advance_s     = EN & CE_R;
    assign accept_s      = BOUNDARY & INT_REQ & (NMI_REQ | (INT_LVL > SR_IN[7:4]));

    // State register; everything freezes unless EN and CE_R are both high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else if (advance_s) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; memory states hold until MEM_WAIT clears.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   if (accept_s)   state_nxt_s = S_ACCEPT; else state_nxt_s = S_IDLE;
            S_ACCEPT: if (INT_REQ)    state_nxt_s = S_VREQ;   else state_nxt_s = S_IDLE;
            S_VREQ:   state_nxt_s = S_VWAIT;
            S_VWAIT:  if (!VECT_WAIT) state_nxt_s = S_PSR;    else state_nxt_s = S_VWAIT;
            S_PSR:    if (!MEM_WAIT)  state_nxt_s = S_PPC;    else state_nxt_s = S_PSR;
            S_PPC:    if (!MEM_WAIT)  state_nxt_s = S_FETCH;  else state_nxt_s = S_PPC;
            S_FETCH:  if (!MEM_WAIT)  state_nxt_s = S_DONE;   else state_nxt_s = S_FETCH;
            S_DONE:   state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Context latches: request context at ACCEPT, vector number when VWAIT releases.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_r <= 4'h0;
            sr_r  <= 32'h0;
            pc_r  <= 32'h0;
            sp_r  <= 32'h0;
            vbr_r <= 32'h0;
            vec_r <= 8'h00;
        end else if (advance_s) begin
            if (state_r == S_ACCEPT && INT_REQ) begin
                lvl_r <= NMI_REQ ? NMI_LEVEL : INT_LVL;
                sr_r  <= SR_IN;
                pc_r  <= PC_IN;
                sp_r  <= SP_IN;
                vbr_r <= VBR;
            end
            if (state_r == S_VWAIT && !VECT_WAIT) begin
                vec_r <= INT_VEC;
            end
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        int_acp_nxt_s  = 1'b0;
        int_ack_nxt_s  = 1'b0;
        vect_req_nxt_s = 1'b0;
        mem_we_nxt_s   = 1'b0;
        mem_req_nxt_s  = 1'b0;
        done_nxt_s     = 1'b0;
        mem_a_nxt_s    = 32'h0;
        mem_do_nxt_s   = 32'h0;
        new_pc_nxt_s   = new_pc_r;
        new_sp_nxt_s   = new_sp_r;
        new_mask_nxt_s = new_mask_r;
        busy_nxt_s     = (state_nxt_s != S_IDLE);
        case (state_nxt_s)
            S_VREQ: begin
                int_acp_nxt_s  = 1'b1;
                vect_req_nxt_s = 1'b1;
            end
            S_PSR: begin
                mem_req_nxt_s = 1'b1;
                mem_we_nxt_s  = 1'b1;
                mem_a_nxt_s   = sp_r - SP_STEP1_W;
                mem_do_nxt_s  = sr_r;
            end
            S_PPC: begin
                mem_req_nxt_s = 1'b1;
                mem_we_nxt_s  = 1'b1;
                mem_a_nxt_s   = sp_r - SP_STEP2_W;
                mem_do_nxt_s  = pc_r;
            end
            S_FETCH: begin
                mem_req_nxt_s = 1'b1;
                mem_a_nxt_s   = vec_addr(vbr_r, vec_r, VEC_SHIFT);
            end
            S_DONE: begin
                // Only reached from FETCH with MEM_WAIT low, so MEM_DI is the handler.
                done_nxt_s     = 1'b1;
                int_ack_nxt_s  = 1'b1;
                new_pc_nxt_s   = MEM_DI;
                new_sp_nxt_s   = sp_r - SP_STEP2_W;
                new_mask_nxt_s = lvl_r;
            end
            default: begin
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears them immediately, aborting any memory cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_acp_r  <= 1'b0;
            int_ack_r  <= 1'b0;
            vect_req_r <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_a_r    <= 32'h0;
            mem_do_r   <= 32'h0;
            new_pc_r   <= 32'h0;
            new_sp_r   <= 32'h0;
            new_mask_r <= 4'h0;
        end else if (advance_s) begin
            int_acp_r  <= int_acp_nxt_s;
            int_ack_r  <= int_ack_nxt_s;
            vect_req_r <= vect_req_nxt_s;
            mem_we_r   <= mem_we_nxt_s;
            mem_req_r  <= mem_req_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            mem_a_r    <= mem_a_nxt_s;
            mem_do_r   <= mem_do_nxt_s;
            new_pc_r   <= new_pc_nxt_s;
            new_sp_r   <= new_sp_nxt_s;
            new_mask_r <= new_mask_nxt_s;
        end
    end

`ifdef SH7604_INTSEQ_STATS_EN
    logic [15:0] int_count_r;

    // Completed-sequence counter, saturating at all ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_count_r <= 16'h0000;
        end else if (advance_s && state_nxt_s == S_DONE && int_count_r != 16'hFFFF) begin
            int_count_r <= int_count_r + 16'h0001;
        end
    end

    assign INT_COUNT = int_count_r;
`endif

    assign INT_ACP  = int_acp_r;
    assign INT_ACK  = int_ack_r;
    assign VECT_REQ = vect_req_r;
    assign MEM_A    = mem_a_r;
    assign MEM_DO   = mem_do_r;
    assign MEM_WE   = mem_we_r;
    assign MEM_REQ  = mem_req_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign NEW_PC   = new_pc_r;
    assign NEW_SP   = new_sp_r;
    assign NEW_MASK = new_mask_r;

endmodule

// File: tb/tb_sh7604_int_seq.sv
// Self-checking bench for sh7604_int_seq: spec-level model plus directed sequences.
module tb_sh7604_int_seq;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } acc_t;

    logic        clk, rst, ce_r, ce_f, en;
    logic        int_req, nmi_req, vect_wait, boundary, mem_wait;
    logic [3:0]  int_lvl;
    logic [7:0]  int_vec;
    logic [31:0] sr_in, pc_in, sp_in, vbr, mem_di;
    logic        int_acp, int_ack, vect_req, mem_we, mem_req, busy, done;
    logic [31:0] mem_a, mem_do, new_pc, new_sp;
    logic [3:0]  new_mask;
`ifdef SH7604_INTSEQ_STATS_EN
    logic [15:0] int_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Model state
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    int          exp_lat = 7;
    acc_t        exp_q[$];
    acc_t        e_tmp, head;
    logic [31:0] m_new_pc = 32'h0, m_new_sp = 32'h0, m_rd_a = 32'h0;
    logic [3:0]  m_mask = 4'h0;
    logic        adv, mem_fire, exp_done, exp_acp;
    logic        done_prev = 1'b0, acp_prev = 1'b0;
    int          done_seen = 0, acp_seen = 0;

    sh7604_int_seq dut (
        .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f), .EN(en),
        .INT_REQ(int_req), .INT_LVL(int_lvl), .NMI_REQ(nmi_req),
        .INT_ACP(int_acp), .INT_ACK(int_ack), .VECT_REQ(vect_req),
        .VECT_WAIT(vect_wait), .INT_VEC(int_vec), .BOUNDARY(boundary),
        .SR_IN(sr_in), .PC_IN(pc_in), .SP_IN(sp_in), .VBR(vbr),
        .MEM_A(mem_a), .MEM_DO(mem_do), .MEM_WE(mem_we), .MEM_REQ(mem_req),
        .MEM_DI(mem_di), .MEM_WAIT(mem_wait), .BUSY(busy), .DONE(done),
        .NEW_PC(new_pc), .NEW_SP(new_sp), .NEW_MASK(new_mask)
`ifdef SH7604_INTSEQ_STATS_EN
        , .INT_COUNT(int_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ce_r = 1'b0;
        ce_f = 1'b1;
        forever begin
            @(negedge clk);
            ce_r = ~ce_r;
            ce_f = ~ce_r;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Wait for the next enabled CE_R edge, then move 1ns past it.
    task automatic step();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!(ce_r && en) && guard < 50);
        if (guard >= 50) begin
            n_total++;
            $display("FAIL step_timeout: got no CE_R edge in %0d clocks", guard);
        end
        #1;
    endtask

    // Model: accept rule, ACCEPT-edge cancel/latch, memory expectations, latency.
    always @(posedge clk) begin
        adv      = ce_r && en && !rst;
        mem_fire = adv && mem_req && !mem_wait;
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else if (adv) begin
            if (mem_fire && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                if (!head.we) m_new_pc = mem_di;
            end
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 1) begin
                    if (!int_req) begin
                        m_busy = 1'b0;
                    end else begin
                        e_tmp.a = sp_in - 32'd4; e_tmp.d = sr_in; e_tmp.we = 1'b1;
                        exp_q.push_back(e_tmp);
                        e_tmp.a = sp_in - 32'd8; e_tmp.d = pc_in; e_tmp.we = 1'b1;
                        exp_q.push_back(e_tmp);
                        m_rd_a  = vbr + 32'(int_vec) * 32'd4;
                        e_tmp.a = m_rd_a; e_tmp.d = 32'd0; e_tmp.we = 1'b0;
                        exp_q.push_back(e_tmp);
                        m_new_sp = sp_in - 32'd8;
                        m_mask   = nmi_req ? 4'hF : int_lvl;
                    end
                end
                if (m_cnt == exp_lat) m_busy = 1'b0;
            end else if (boundary && int_req && (nmi_req || int_lvl > sr_in[7:4])) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        #2;
        if (!rst) begin
            exp_done = m_busy && (m_cnt == exp_lat - 1);
            exp_acp  = m_busy && (m_cnt == 1);
            chk("busy", busy, m_busy);
            chk("done", done, exp_done);
            chk("int_ack", int_ack, exp_done);
            chk("int_acp", int_acp, exp_acp);
            chk("vect_req", vect_req, exp_acp);
            if (mem_req) begin
                if (!m_busy || exp_q.size() == 0) begin
                    chk("mem_req_unexpected", mem_req, 1'b0);
                end else begin
                    chk("mem_a", mem_a, exp_q[0].a);
                    chk("mem_we", mem_we, exp_q[0].we);
                    if (exp_q[0].we) chk("mem_do", mem_do, exp_q[0].d);
                end
            end
            if (exp_done) begin
                chk("new_pc", new_pc, m_new_pc);
                chk("new_sp", new_sp, m_new_sp);
                chk("new_mask", new_mask, m_mask);
                chk("mem_cycles_left", exp_q.size(), 32'd0);
            end
            if (done && !done_prev) done_seen++;
            if (int_acp && !acp_prev) acp_seen++;
            done_prev = done;
            acp_prev  = int_acp;
        end
    end

    // One zero-wait sequence; request context is scrambled after ACCEPT.
    task automatic run_seq(input logic [31:0] sr, input logic [3:0] lvl, input logic nmi,
                           input logic [7:0] vec, input logic [31:0] vb, input logic [31:0] sp,
                           input logic [31:0] pc, input logic [31:0] di, input logic freeze);
        sr_in = sr; int_lvl = lvl; nmi_req = nmi; int_vec = vec; vbr = vb;
        sp_in = sp; pc_in = pc; mem_di = di; mem_wait = 1'b0; vect_wait = 1'b0;
        exp_lat = 7;
        boundary = 1'b1; int_req = 1'b1;
        step();
        step();
        boundary = 1'b0; int_req = 1'b0; nmi_req = 1'b0; int_lvl = 4'h0;
        sr_in = 32'hBAD0_0001; pc_in = 32'hBAD0_0002; sp_in = 32'hBAD0_0003;
        if (freeze) begin
            en = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            en = 1'b1;
        end
        repeat (7) step();
        mem_di = 32'h0;
    endtask

    int a0, d0;

    initial begin
        rst = 1'b0; en = 1'b1; int_req = 1'b0; nmi_req = 1'b0; vect_wait = 1'b0;
        boundary = 1'b0; mem_wait = 1'b0; int_lvl = 4'h0; int_vec = 8'h00;
        sr_in = 32'h0; pc_in = 32'h0; sp_in = 32'h0; vbr = 32'h0; mem_di = 32'h0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_int_acp", int_acp, 1'b0);
        rst = 1'b0;
        repeat (2) step();

        // Basic level-5 interrupt over mask 3
        a0 = acp_seen; d0 = done_seen;
        run_seq(32'h0000_0030, 4'h5, 1'b0, 8'h41, 32'h0600_0000, 32'h0600_4000,
                32'h0600_0ABC, 32'h0600_2000, 1'b0);
        chk("t1_acp_count", acp_seen - a0, 32'd1);
        chk("t1_done_count", done_seen - d0, 32'd1);
        chk("t1_new_pc", new_pc, 32'h0600_2000);
        chk("t1_new_sp", new_sp, 32'h0600_3FF8);
        chk("t1_new_mask", new_mask, 4'h5);
        chk("t1_model_rd", m_rd_a, 32'h0600_0104);
        chk("t1_busy_end", busy, 1'b0);

        // Equal level is not accepted; nor is a higher level off-boundary
        a0 = acp_seen;
        sr_in = 32'h0000_0030; int_lvl = 4'h3; boundary = 1'b1; int_req = 1'b1;
        repeat (3) step();
        chk("t2_busy_eq", busy, 1'b0);
        int_lvl = 4'h4; boundary = 1'b0;
        repeat (3) step();
        chk("t2_busy_noboundary", busy, 1'b0);
        chk("t2_acp_count", acp_seen - a0, 32'd0);
        int_req = 1'b0; int_lvl = 4'h0;

        // NMI over mask F, SP wrap, with an EN freeze while INT_ACP is high
        a0 = acp_seen;
        run_seq(32'h0000_00F0, 4'h2, 1'b1, 8'd11, 32'h0000_1000, 32'h0000_0004,
                32'h0000_0200, 32'h0000_3000, 1'b1);
        chk("t3_acp_count", acp_seen - a0, 32'd1);
        chk("t3_new_mask", new_mask, 4'hF);
        chk("t3_new_sp", new_sp, 32'hFFFF_FFFC);
        chk("t3_model_rd", m_rd_a, 32'h0000_102C);
        chk("t3_new_pc", new_pc, 32'h0000_3000);

        // VECT_WAIT for 5 CE_R, MEM_WAIT for 3 CE_R per cycle, vector address wraps
        sr_in = 32'h0000_0301; int_lvl = 4'h9; int_vec = 8'h80; vbr = 32'hFFFF_FE00;
        sp_in = 32'h0000_8000; pc_in = 32'h1234_5678; exp_lat = 21;
        vect_wait = 1'b1; mem_wait = 1'b1; mem_di = 32'hDEAD_BEEF;
        boundary = 1'b1; int_req = 1'b1;
        d0 = done_seen;
        for (int k = 0; k <= 21; k++) begin
            step();
            if (k == 1) begin
                boundary = 1'b0; int_req = 1'b0; int_lvl = 4'h0;
            end
            vect_wait = (k + 1 <= 7);
            mem_wait  = !((k + 1 == 12) || (k + 1 == 16) || (k + 1 == 20));
            mem_di    = (k + 1 == 20) ? 32'h0000_4444 : 32'hDEAD_BEEF;
        end
        mem_wait = 1'b0; vect_wait = 1'b0; mem_di = 32'h0;
        chk("t4_done_count", done_seen - d0, 32'd1);
        chk("t4_new_pc", new_pc, 32'h0000_4444);
        chk("t4_new_sp", new_sp, 32'h0000_7FF8);
        chk("t4_model_rd", m_rd_a, 32'h0000_0000);

        // INT_REQ withdrawn at the ACCEPT edge cancels the sequence
        a0 = acp_seen; d0 = done_seen; exp_lat = 7;
        sr_in = 32'h0; int_lvl = 4'h4; boundary = 1'b1; int_req = 1'b1;
        step();
        chk("t5_busy_accept", busy, 1'b1);
        int_req = 1'b0; boundary = 1'b0;
        step();
        chk("t5_busy_cancel", busy, 1'b0);
        repeat (3) step();
        chk("t5_acp_count", acp_seen - a0, 32'd0);
        chk("t5_done_count", done_seen - d0, 32'd0);

        // Reset during PPC, then a clean sequence
        sr_in = 32'h0000_0030; int_lvl = 4'h5; int_vec = 8'h41; vbr = 32'h0600_0000;
        sp_in = 32'h0600_4000; pc_in = 32'h0600_0ABC; mem_di = 32'h0600_2000;
        boundary = 1'b1; int_req = 1'b1;
        step();
        step();
        boundary = 1'b0; int_req = 1'b0;
        repeat (3) step();
        chk("t6_ppc_addr", mem_a, 32'h0600_3FF8);
        chk("t6_ppc_data", mem_do, 32'h0600_0ABC);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_mem_req", mem_req, 1'b0);
        chk("t6_rst_mem_we", mem_we, 1'b0);
        chk("t6_rst_mem_a", mem_a, 32'h0);
        chk("t6_rst_mem_do", mem_do, 32'h0);
        chk("t6_rst_new_pc", new_pc, 32'h0);
        chk("t6_rst_new_sp", new_sp, 32'h0);
        chk("t6_rst_new_mask", new_mask, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step();
        d0 = done_seen;
        run_seq(32'h0000_0030, 4'h5, 1'b0, 8'h41, 32'h0600_0000, 32'h0600_4000,
                32'h0600_0ABC, 32'h0600_2000, 1'b0);
        chk("t6_done_count", done_seen - d0, 32'd1);
        chk("t6_new_sp", new_sp, 32'h0600_3FF8);
`ifdef SH7604_INTSEQ_STATS_EN
        chk("t6_int_count", int_count, 32'd1);
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
